ysyx_23060203_mdu: RTL and testbench

YSYX_23060203_MDU -- requirements
Module: ysyx_23060203_MDU

---
 rtl/ysyx_23060203_mdu.sv | 166 ++++++++++++++++
 tb/tb_ysyx_23060203_mdu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_mdu.sv
// RV M-extension multiply/divide unit.
// Iterative shift-add multiplier, restoring divider, valid/ready handshake.
module ysyx_23060203_mdu #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int MSTEPS = XLEN / MUL_BPC;
  localparam int PW = XLEN + MUL_BPC;

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   p;
  logic [XLEN-1:0]     m;
  logic [2:0]          fq;
  logic                an;
  logic                bn;
  logic [XLEN-1:0]     res;

  logic                sa;
  logic                sbs;
  logic                an_in;
  logic                bn_in;
  logic                div0;
  logic                ovf;
  logic [XLEN-1:0]     ma;
  logic [XLEN-1:0]     mb;
  logic [XLEN-1:0]     fast_res;

  logic [PW-1:0]       partial;
  logic [PW-1:0]       msum;
  logic [2*XLEN-1:0]   p_mul;
  logic [XLEN:0]       t;
  logic                ge;
  logic [XLEN-1:0]     rsub;
  logic [2*XLEN-1:0]   p_div;
  logic [2*XLEN-1:0]   p_nx;

  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     fin;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE) & ~flush;
  assign out_result = res;

  // Request decode: signedness, magnitudes and the one-cycle special cases
  always_comb begin
    sa = (in_funct == 3'b001) | (in_funct == 3'b010) |
         (in_funct == 3'b100) | (in_funct == 3'b110);
    sbs = (in_funct == 3'b001) | (in_funct == 3'b100) |
          (in_funct == 3'b110);
    an_in = sa & in_a[XLEN-1];
    bn_in = sbs & in_b[XLEN-1];
    ma = an_in ? -in_a : in_a;
    mb = bn_in ? -in_b : in_b;
    div0 = in_funct[2] & (in_b == '0);
    ovf = in_funct[2] & ~in_funct[0] &
          (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
    if (div0)
      fast_res = in_funct[1] ? in_a : '1;
    else
      fast_res = in_funct[1] ? '0 : in_a;
  end

  // One iteration step: MUL_BPC-bit shift-add or one restoring divide bit
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BPC; i++)
      if (p[i])
        partial = partial + (PW'(m) << i);
    msum  = partial + PW'(p[2*XLEN-1:XLEN]);
    p_mul = {msum, p[XLEN-1:MUL_BPC]};
    t     = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    ge    = (t >= {1'b0, m});
    rsub  = t[XLEN-1:0] - m;
    p_div = {(ge ? rsub : t[XLEN-1:0]), p[XLEN-2:0], ge};
    p_nx  = (state == MUL) ? p_mul : p_div;
  end

  // Sign fix-up and result select from the final iteration
  always_comb begin
    prod = (an ^ bn) ? -p_nx : p_nx;
    quo  = (an ^ bn) ? -p_nx[XLEN-1:0] : p_nx[XLEN-1:0];
    rem  = an ? -p_nx[2*XLEN-1:XLEN] : p_nx[2*XLEN-1:XLEN];
    fin  = '0;
    unique case (1'b1)
      (fq == 3'b000):          fin = prod[XLEN-1:0];
      (!fq[2] && fq != 3'b0):  fin = prod[2*XLEN-1:XLEN];
      (fq[2] && !fq[1]):       fin = quo;
      (fq[2] && fq[1]):        fin = rem;
    endcase
  end

  // Control FSM with datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      m     <= '0;
      fq    <= '0;
      an    <= 1'b0;
      bn    <= 1'b0;
      res   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            fq  <= in_funct;
            an  <= an_in;
            bn  <= bn_in;
            cnt <= in_funct[2] ? CW'(XLEN) : CW'(MSTEPS);
            if (div0 | ovf) begin
              state <= DONE;
              res   <= fast_res;
            end else if (in_funct[2]) begin
              state <= DIV;
              p     <= {{XLEN{1'b0}}, ma};
              m     <= mb;
            end else begin
              state <= MUL;
              p     <= {{XLEN{1'b0}}, mb};
              m     <= ma;
            end
          end
        end
        MUL, DIV: begin
          p <= p_nx;
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            res   <= fin;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_mdu.sv
// Scoreboard bench for the MDU: one 32-bit instance (MUL_BPC=2)
// and three 64-bit instances (MUL_BPC=1, 4, 8).
module tb_ysyx_23060203_mdu;

  logic        clock = 1'b0;
  logic        reset;
  logic        fl[4];
  logic        iv[4];
  logic        ordy[4];
  logic [2:0]  fn[4];
  logic [63:0] a[4];
  logic [63:0] b[4];
  logic        irdy[4];
  logic        ov[4];
  logic [63:0] res[4];
  logic [31:0] r32;

  always #5 clock = ~clock;

  assign res[0] = {32'h0, r32};

  ysyx_23060203_mdu #(.XLEN(32), .MUL_BPC(2)) u0 (
    .clock(clock), .reset(reset), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_funct(fn[0]),
    .in_a(a[0][31:0]), .in_b(b[0][31:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_result(r32)
  );

  for (genvar g = 1; g < 4; g++) begin : g64
    ysyx_23060203_mdu #(
      .XLEN(64), .MUL_BPC(g == 1 ? 1 : (g == 2 ? 4 : 8))
    ) u (
      .clock(clock), .reset(reset), .flush(fl[g]),
      .in_valid(iv[g]), .in_ready(irdy[g]), .in_funct(fn[g]),
      .in_a(a[g]), .in_b(b[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_result(res[g])
    );
  end

  typedef struct {
    int          dut;
    logic [63:0] val;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs[4] = '{0, 0, 0, 0};
  logic pv[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // handshake counter, sampled with pre-edge values
  always @(posedge clock)
    for (int k = 0; k < 4; k++)
      if (ov[k] && ordy[k]) hs[k]++;

  // monitor: compare on the first cycle each DUT raises out_valid
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && !pv[k]) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid dut=%0d got=%h want=none",
                     k, res[k]);
          end else begin
            e = sbq.pop_front();
            chk({e.nm, "_dut"}, 64'(k), 64'(e.dut));
            chk(e.nm, res[k], e.val);
            chk({e.nm, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
          end
        end
        pv[k] = ov[k];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic run_op(input int k, input logic [2:0] f,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] ev, input int lat,
                        input string nm);
    exp_t e;
    int   t;
    @(negedge clock);
    t = 0;
    while (!irdy[k] && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!irdy[k]) begin
      tests++;
      fails++;
      $display("FAIL %s_accept got=timeout want=in_ready", nm);
      return;
    end
    fn[k] = f;
    a[k]  = x;
    b[k]  = y;
    iv[k] = 1'b1;
    e.dut = k;
    e.val = ev;
    e.lat = lat;
    e.acc = cyc + 1;
    e.nm  = nm;
    sbq.push_back(e);
    @(negedge clock);
    iv[k] = 1'b0;
    t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_done got=timeout want=out_valid", nm);
      sbq.delete();
    end
  endtask

  task automatic r32op(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ev,
                       input bit fast, input string nm);
    int lat;
    lat = fast ? 1 : (f[2] ? 33 : 17);
    run_op(0, f, {32'h0, x}, {32'h0, y}, {32'h0, ev}, lat, nm);
  endtask

  task automatic r64op(input int k, input logic [2:0] f,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] ev, input bit fast,
                       input string nm);
    int lat;
    int bpc;
    bpc = (k == 1) ? 1 : ((k == 2) ? 4 : 8);
    lat = fast ? 1 : (f[2] ? 65 : 64 / bpc + 1);
    run_op(k, f, x, y, ev, lat, nm);
  endtask

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int h0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fl[k] = 0; iv[k] = 0; ordy[k] = 1;
      fn[k] = 0; a[k] = 0; b[k] = 0;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", 64'(irdy[k]), 64'd1);
      chk("rst_out_valid", 64'(ov[k]), 64'd0);
      chk("rst_result", res[k], 64'd0);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rel_in_ready", 64'(irdy[0]), 64'd1);
    chk("rel_out_valid", 64'(ov[0]), 64'd0);
    chk("rel_result", res[0], 64'd0);

    r32op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul32");
    r32op(3'b000, 32'h12345, 32'h100, 32'h01234500, 0, "mul32b");
    r32op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh32");
    r32op(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulhu32");
    r32op(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, "mulhsu32");
    r32op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu32b");
    r32op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, "mulh32b");
    r32op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, "div32");
    r32op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, "rem32");
    r32op(3'b101, 32'd100, 32'd7, 32'd14, 0, "divu32");
    r32op(3'b111, 32'd100, 32'd7, 32'd2, 0, "remu32");
    r32op(3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 0, "rem32b");
    r32op(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, "div32b");
    r32op(3'b100, 32'h80000000, 32'd1, 32'h80000000, 0, "div32min");
    r32op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu32_z");
    r32op(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu32_z");
    r32op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div32_ovf");
    r32op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem32_ovf");

    for (int k = 1; k < 4; k++) begin
      r64op(k, 3'b000, 64'd7, ONES - 64'd2, ONES - 64'd20, 0, "mul64");
      r64op(k, 3'b001, MIN64, MIN64, 64'h4000_0000_0000_0000, 0, "mulh64");
      r64op(k, 3'b011, MIN64, MIN64, 64'h4000_0000_0000_0000, 0, "mulhu64");
      r64op(k, 3'b010, ONES, 64'd2, ONES, 0, "mulhsu64");
      r64op(k, 3'b100, ONES - 64'd6, 64'd2, ONES - 64'd2, 0, "div64");
      r64op(k, 3'b110, ONES - 64'd6, 64'd2, ONES, 0, "rem64");
      r64op(k, 3'b101, 64'd5, 64'd0, ONES, 1, "divu64_z");
      r64op(k, 3'b100, MIN64, ONES, MIN64, 1, "div64_ovf");
    end

    // backpressure in DONE
    ordy[0] = 1'b0;
    r32op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, "bp_mul");
    h0 = hs[0];
    repeat (5) begin
      @(negedge clock);
      chk("bp_valid", 64'(ov[0]), 64'd1);
      chk("bp_result", res[0], 64'h0000_0000_FFFF_FFEB);
      chk("bp_in_ready", 64'(irdy[0]), 64'd0);
    end
    ordy[0] = 1'b1;
    @(negedge clock);
    chk("bp_in_ready_after", 64'(irdy[0]), 64'd1);
    chk("bp_valid_after", 64'(ov[0]), 64'd0);
    repeat (3) @(negedge clock);
    chk("bp_handshakes", 64'(hs[0] - h0), 64'd1);

    // flush while holding a result in DONE
    ordy[0] = 1'b0;
    r32op(3'b101, 32'd100, 32'd7, 32'd14, 0, "fl_divu");
    h0 = hs[0];
    fl[0] = 1'b1;
    #1;
    chk("fl_done_comb", 64'(ov[0]), 64'd0);
    @(negedge clock);
    fl[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("fl_done_idle", 64'(irdy[0]), 64'd1);
    chk("fl_done_valid", 64'(ov[0]), 64'd0);
    chk("fl_done_hs", 64'(hs[0] - h0), 64'd0);

    // flush beats an accept in IDLE
    fl[0] = 1'b1; iv[0] = 1'b1;
    fn[0] = 3'b000; a[0] = 64'd3; b[0] = 64'd3;
    @(negedge clock);
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("fl_idle_noaccept", 64'(irdy[0]), 64'd1);

    // flush on cycle 10 of a DIV with a new request present
    fn[0] = 3'b101; a[0] = 64'd100; b[0] = 64'd7; iv[0] = 1'b1;
    @(negedge clock);
    iv[0] = 1'b0;
    chk("fl_div_busy", 64'(irdy[0]), 64'd0);
    repeat (9) @(negedge clock);
    fl[0] = 1'b1; iv[0] = 1'b1;
    fn[0] = 3'b000; a[0] = 64'd2; b[0] = 64'd2;
    #1;
    chk("fl_div_valid", 64'(ov[0]), 64'd0);
    @(negedge clock);
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("fl_div_idle", 64'(irdy[0]), 64'd1);
    @(negedge clock);
    chk("fl_div_noaccept", 64'(irdy[0]), 64'd1);
    repeat (40) @(negedge clock);
    chk("fl_div_quiet", 64'(ov[0]), 64'd0);

    // reset in the middle of a multiply
    fn[2] = 3'b000; a[2] = 64'd3; b[2] = 64'd5; iv[2] = 1'b1;
    @(negedge clock);
    iv[2] = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rmid_in_ready", 64'(irdy[2]), 64'd1);
    chk("rmid_valid", 64'(ov[2]), 64'd0);
    chk("rmid_result", res[2], 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("rmid_quiet", 64'(ov[2]), 64'd0);
    chk("rmid_idle", 64'(irdy[2]), 64'd1);

    r64op(2, 3'b000, 64'd3, 64'd5, 64'd15, 0, "post_rst_mul");
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
